// File: rtl/alu_execute_unit_if.sv
// Bundle between the control unit and the ALU execute stage.
//
// Handshake: the master raises start for one cycle with opcode/a/b valid.
// start is taken only while busy=0; the cycle after an accepted start,
// busy=1 marks an iterative op in flight. During busy=1 start is ignored
// and nothing is queued. done pulses high for exactly one cycle, and in that
// cycle result, flags and divByZero are valid. result and divByZero hold
// their values until the next done. rstFlag is independent of start and
// clears flagE/flagGt on any edge.
interface alu_execute_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rstFlag;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             flagE;
  logic             flagGt;
  logic             divByZero;

  modport master (
    output start, opcode, a, b, rstFlag,
    input  result, busy, done, flagE, flagGt, divByZero
  );

  modport slave (
    input  start, opcode, a, b, rstFlag,
    output result, busy, done, flagE, flagGt, divByZero
  );
endinterface

// File: rtl/alu_execute_unit.sv
// Execute stage: single-cycle ALU ops plus iterative MUL/DIV/MOD that
// produce one bit per clock on operand magnitudes, followed by sign fixup.
// The last iteration registers the final result and done together; the
// FIN cycle that follows behaves like IDLE so a new start is accepted
// in the same cycle that done is seen.
module alu_execute_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  alu_execute_unit_if.slave  bus,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_OR  = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_MOV = 5'd9;
  localparam logic [4:0] OP_LSL = 5'd10;
  localparam logic [4:0] OP_LSR = 5'd11;
  localparam logic [4:0] OP_ASR = 5'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;    // MUL accumulator / DIV partial remainder
  logic [WIDTH-1:0] x;      // MUL multiplicand / DIV dividend shifting into quotient
  logic [WIDTH-1:0] y;      // MUL multiplier / DIV divisor
  logic [4:0]       op_q;
  logic             neg_q;  // result of MUL/DIV is negative
  logic             sa_q;   // sign of a, gives sign of remainder
  logic             dz_q;   // DIV/MOD with b==0

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_iter;
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic [WIDTH-1:0] fin_result;

  assign state_dbg = state;
  assign sh        = bus.b[SHW-1:0];
  assign a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign is_iter   = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV) ||
                     (bus.opcode == OP_MOD);

  // Single-cycle datapath; CMP keeps result, unknown opcodes yield zero.
  always_comb begin
    sc_result = '0;
    case (bus.opcode)
      OP_ADD:  sc_result = bus.a + bus.b;
      OP_SUB:  sc_result = bus.a - bus.b;
      OP_CMP:  sc_result = bus.result;
      OP_AND:  sc_result = bus.a & bus.b;
      OP_OR:   sc_result = bus.a | bus.b;
      OP_NOT:  sc_result = ~bus.b;
      OP_MOV:  sc_result = bus.b;
      OP_LSL:  sc_result = bus.a << sh;
      OP_LSR:  sc_result = bus.a >> sh;
      OP_ASR:  sc_result = $signed(bus.a) >>> sh;
      default: sc_result = '0;
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide.
  always_comb begin
    mul_next     = acc + (y[0] ? x : '0);
    div_shift    = {acc, x[WIDTH-1]};
    div_trial    = div_shift - {1'b0, y};
    div_rem_next = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quo_next = {x[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  // Sign correction applied to the values produced by the final iteration.
  always_comb begin
    fin_result = neg_q ? -mul_next : mul_next;
    if (op_q == OP_DIV) begin
      fin_result = dz_q ? '1 : (neg_q ? -div_quo_next : div_quo_next);
    end else if (op_q == OP_MOD) begin
      fin_result = sa_q ? -div_rem_next : div_rem_next;
    end
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      count         <= '0;
      acc           <= '0;
      x             <= '0;
      y             <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      sa_q          <= 1'b0;
      dz_q          <= 1'b0;
      bus.result    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.flagE     <= 1'b0;
      bus.flagGt    <= 1'b0;
      bus.divByZero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          if (bus.start) begin
            if (is_iter) begin
              op_q     <= bus.opcode;
              sa_q     <= bus.a[WIDTH-1];
              neg_q    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              dz_q     <= (bus.opcode != OP_MUL) && (bus.b == '0);
              acc      <= '0;
              x        <= a_mag;
              y        <= b_mag;
              count    <= CW'(WIDTH);
              bus.busy <= 1'b1;
              state    <= (bus.opcode == OP_MUL) ? S_MUL : S_DIV;
            end else begin
              bus.result <= sc_result;
              bus.done   <= 1'b1;
              if (bus.opcode <= OP_ASR) begin
                bus.divByZero <= 1'b0;
              end
              if (bus.opcode == OP_CMP) begin
                bus.flagE  <= (bus.a == bus.b);
                bus.flagGt <= ($signed(bus.a) > $signed(bus.b));
              end
            end
          end
        end
        S_MUL: begin
          acc   <= mul_next;
          x     <= x << 1;
          y     <= y >> 1;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bus.result    <= fin_result;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.divByZero <= 1'b0;
            state         <= S_FIN;
          end
        end
        S_DIV: begin
          acc   <= div_rem_next;
          x     <= div_quo_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bus.result    <= fin_result;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.divByZero <= dz_q;
            state         <= S_FIN;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (bus.rstFlag) begin
        bus.flagE  <= 1'b0;
        bus.flagGt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Bench for alu_execute_unit: table of single-cycle ops, hand sequences for
// flags, iterative ops, ignored starts and mid-op reset.
module tb_alu_execute_unit;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  alu_execute_unit_if #(.WIDTH(32)) bus ();

  alu_execute_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one op, wait for done, check latency, busy length, result, divByZero.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res, input logic exp_dz,
                        input int exp_lat, input bit rflag, input bit noise);
    logic [31:0] e;
    int          lat;
    int          busy_n;
    bit          got;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.opcode  = op;
    bus.a       = av;
    bus.b       = bv;
    bus.rstFlag = rflag;
    exp_q.push_back(exp_res);
    lat    = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
      bus.rstFlag = 1'b0;
      if (noise && bus.busy && !got) begin
        bus.start  = 1'b1;
        bus.opcode = 5'd0;
        bus.a      = $urandom;
        bus.b      = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    e = exp_q.pop_front();
    if (got) begin
      check({name, " result"}, bus.result, e);
      check({name, " divByZero"}, 32'(bus.divByZero), 32'(exp_dz));
    end
    @(negedge clk);
    check({name, " done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic check_flags(input string name, input logic e, input logic gt);
    check({name, " flagE"}, 32'(bus.flagE), 32'(e));
    check({name, " flagGt"}, 32'(bus.flagGt), 32'(gt));
  endtask

  initial begin
    int          ra;
    int          rb;
    logic [31:0] rexp;
    int          done_n;

    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{5'd0,  32'd7,          32'd5,          32'd12};
    vecs[1]  = '{5'd1,  32'd5,          32'd7,          32'hFFFF_FFFE};
    vecs[2]  = '{5'd0,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
    vecs[3]  = '{5'd6,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
    vecs[4]  = '{5'd7,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0};
    vecs[5]  = '{5'd8,  32'h1234_5678,  32'h0000_FFFF,  32'hFFFF_0000};
    vecs[6]  = '{5'd9,  32'hDEAD_BEEF,  32'h1234_5678,  32'h1234_5678};
    vecs[7]  = '{5'd10, 32'd1,          32'd31,         32'h8000_0000};
    vecs[8]  = '{5'd11, 32'h8000_0000,  32'd36,         32'h0800_0000};
    vecs[9]  = '{5'd12, 32'h8000_0000,  32'd36,         32'hF800_0000};
    vecs[10] = '{5'd13, 32'd3,          32'd4,          32'h0000_0000};

    bus.start   = 1'b0;
    bus.opcode  = 5'd0;
    bus.a       = '0;
    bus.b       = '0;
    bus.rstFlag = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check("reset result", bus.result, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset flagE", 32'(bus.flagE), 32'd0);
    check("reset flagGt", 32'(bus.flagGt), 32'd0);
    check("reset divByZero", 32'(bus.divByZero), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1, 1'b0, 1'b0);
    end

    // Compare flags and rstFlag priority.
    run_op("add7_5", 5'd0, 32'd7, 32'd5, 32'd12, 1'b0, 1, 1'b0, 1'b0);
    run_op("cmp_m3_2", 5'd5, 32'hFFFF_FFFD, 32'd2, 32'd12, 1'b0, 1, 1'b0, 1'b0);
    check_flags("cmp_m3_2", 1'b0, 1'b0);
    run_op("cmp_5_1", 5'd5, 32'd5, 32'd1, 32'd12, 1'b0, 1, 1'b0, 1'b0);
    check_flags("cmp_5_1", 1'b0, 1'b1);
    run_op("cmp_9_9", 5'd5, 32'd9, 32'd9, 32'd12, 1'b0, 1, 1'b0, 1'b0);
    check_flags("cmp_9_9", 1'b1, 1'b0);
    run_op("bad_op", 5'd20, 32'd9, 32'd9, 32'd0, 1'b0, 1, 1'b0, 1'b0);
    check_flags("bad_op", 1'b1, 1'b0);
    run_op("cmp_rstflag", 5'd5, 32'd5, 32'd1, 32'd0, 1'b0, 1, 1'b1, 1'b0);
    check_flags("cmp_rstflag", 1'b0, 1'b0);

    // Iterative ops.
    run_op("mul_ff_3", 5'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 33, 1'b0, 1'b0);
    run_op("div_m7_2", 5'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1'b0, 1'b0);
    run_op("mod_m7_2", 5'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1'b0, 1'b0);
    run_op("div_5_0", 5'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 33, 1'b0, 1'b0);
    run_op("mod_m5_0", 5'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 33, 1'b0, 1'b0);
    run_op("bad_op_dz", 5'd31, 32'd1, 32'd1, 32'd0, 1'b1, 1, 1'b0, 1'b0);
    run_op("add_clr_dz", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b0, 1'b0);
    run_op("div_noise", 5'd3, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = int'($urandom);
      rb = int'($urandom_range(2, 1000));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      case (i % 3)
        0:       rexp = 32'(ra * rb);
        1:       rexp = 32'(ra / rb);
        default: rexp = 32'(ra % rb);
      endcase
      run_op($sformatf("rand%0d", i), 5'(2 + (i % 3)), 32'(ra), 32'(rb), rexp, 1'b0, 33, 1'b0, 1'b0);
    end

    // Reset in the middle of a divide: no done, outputs cleared.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = 5'd3;
    bus.a      = 32'd1000;
    bus.b      = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("midop busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst result", bus.result, 32'd0);
    check("midrst state", 32'(state_dbg), 32'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("midrst no_done", 32'(done_n), 32'd0);
    run_op("add1_1", 5'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1, 1'b0, 1'b0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
